// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: two producer handshakes and
// the register-file write port with its pending mask.
interface wb_arbiter_if #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 4
);
  logic                     alu_valid;
  logic                     alu_ready;
  logic [ADDR_W-1:0]        alu_waddr;
  logic [DATA_W-1:0]        alu_wdata;
  logic                     mem_valid;
  logic                     mem_ready;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [(1<<ADDR_W)-1:0]   pending;

  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    input  alu_ready, mem_ready,
    input  we, waddr, wdata, pending
  );

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    output alu_ready, mem_ready,
    output we, waddr, wdata, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per producer,
// memory priority with an ALU anti-starvation age.
module wb_arbiter #(
  parameter int DATA_W     = 19,
  parameter int ADDR_W     = 4,
  parameter int STARVE_LIM = 3
) (
  input logic         clk,
  input logic         rst_n,
  wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [2:0] LIM = 3'(STARVE_LIM);

  logic              alu_full_q, alu_full_d;
  logic [ADDR_W-1:0] alu_addr_q, alu_addr_d;
  logic [DATA_W-1:0] alu_data_q, alu_data_d;
  logic              mem_full_q, mem_full_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic [2:0]        age_q, age_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              alu_gnt, mem_gnt;
  logic              alu_load, mem_load;
  logic [NREG-1:0]   pend;

  // Grant from registered slot state; ALU wins once starved.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    unique case ({alu_full_q, mem_full_q})
      2'b10:   alu_gnt = 1'b1;
      2'b01:   mem_gnt = 1'b1;
      2'b11: begin
        if (age_q >= LIM) alu_gnt = 1'b1;
        else              mem_gnt = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_ready = !alu_full_q || alu_gnt;
  assign bus.mem_ready = !mem_full_q || mem_gnt;

  // Writes to R0 are accepted but never stored.
  assign alu_load = bus.alu_valid && bus.alu_ready
                 && (bus.alu_waddr != '0);
  assign mem_load = bus.mem_valid && bus.mem_ready
                 && (bus.mem_waddr != '0);

  // Next state: drain the winner, refill on handshake, age the ALU.
  always_comb begin
    alu_full_d = alu_full_q;
    alu_addr_d = alu_addr_q;
    alu_data_d = alu_data_q;
    mem_full_d = mem_full_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    age_d      = 3'd0;
    we_d       = alu_gnt || mem_gnt;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (alu_gnt) begin
      alu_full_d = 1'b0;
      waddr_d    = alu_addr_q;
      wdata_d    = alu_data_q;
    end else if (mem_gnt) begin
      mem_full_d = 1'b0;
      waddr_d    = mem_addr_q;
      wdata_d    = mem_data_q;
    end
    if (alu_full_q && !alu_gnt) begin
      age_d = (age_q == 3'd7) ? 3'd7 : age_q + 3'd1;
    end
    if (alu_load) begin
      alu_full_d = 1'b1;
      alu_addr_d = bus.alu_waddr;
      alu_data_d = bus.alu_wdata;
    end
    if (mem_load) begin
      mem_full_d = 1'b1;
      mem_addr_d = bus.mem_waddr;
      mem_data_d = bus.mem_wdata;
    end
  end

  // State registers; reset drops every held or presented write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full_q <= 1'b0;
      alu_addr_q <= '0;
      alu_data_q <= '0;
      mem_full_q <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      age_q      <= 3'd0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      alu_full_q <= alu_full_d;
      alu_addr_q <= alu_addr_d;
      alu_data_q <= alu_data_d;
      mem_full_q <= mem_full_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      age_q      <= age_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Destinations still in flight, for the decode interlock.
  always_comb begin
    pend = '0;
    if (alu_full_q) pend[alu_addr_q] = 1'b1;
    if (mem_full_q) pend[mem_addr_q] = 1'b1;
    if (we_q)       pend[waddr_q]    = 1'b1;
  end

  assign bus.we      = we_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.pending = pend;

endmodule
